dds_multi_voice_gen: RTL and testbench

//  Parametrised successor to the single-increment DDS/LFSR path: NUM_CH time-multiplexed DDS voices.

---
 rtl/dds_multi_voice_gen.sv | 206 ++++++++++++++++++++
 tb/tb_dds_multi_voice_gen.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dds_multi_voice_gen.sv
`default_nettype none
// ============================================================================
// Module   : dds_multi_voice_gen
// Desc     : NUM_CH time-multiplexed DDS voices (saw / square / triangle /
//            LFSR noise) with per-voice gain. One mixed, saturated sample is
//            pushed into the audio FIFO per accepted sample_strobe.
// Revision : 1.0 - initial release
// ============================================================================
module dds_multi_voice_gen #(
  parameter int                NUM_CH    = 4,
  parameter int                ACC_W     = 32,
  parameter int                OUT_W     = 16,
  parameter int                LFSR_W    = 32,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 32'h80200003,
  localparam int               CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic             sample_strobe,
  input  logic             cfg_wr,
  input  logic [CH_W-1:0]  cfg_chan,
  input  logic [1:0]       cfg_sel,
  input  logic [ACC_W-1:0] cfg_data,
  input  logic             fifo_full,
  output logic             fifo_wrreq,
  output logic [OUT_W-1:0] fifo_data,
  output logic             busy,
  output logic [15:0]      drop_count,
  output logic             strobe_miss
);

  localparam int MIX_W = OUT_W + CH_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_PUSH = 2'd2;

  localparam logic [CH_W-1:0]         LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic [OUT_W-1:0]        OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]        OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0]        SQ_NEG  = {1'b1, {(OUT_W-2){1'b0}}, 1'b1};
  localparam logic signed [MIX_W-1:0] MIX_MAX = {{(MIX_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [MIX_W-1:0] MIX_MIN = {{(MIX_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [1:0]              state, state_nxt;
  logic [CH_W-1:0]         ch;
  logic signed [MIX_W-1:0] mix;
  logic [LFSR_W-1:0]       lfsr;
  logic [OUT_W-1:0]        last_data;

  // Shadow (CSR-visible) and active (frame-frozen) voice settings
  logic [ACC_W-1:0] inc_sh [NUM_CH];
  logic [ACC_W-1:0] ld_sh  [NUM_CH];
  logic [1:0]       mode_sh[NUM_CH];
  logic [7:0]       gain_sh[NUM_CH];
  logic             en_sh  [NUM_CH];
  logic             pend_sh[NUM_CH];
  logic [ACC_W-1:0] inc    [NUM_CH];
  logic [ACC_W-1:0] ld     [NUM_CH];
  logic [1:0]       mode   [NUM_CH];
  logic [7:0]       gain   [NUM_CH];
  logic             en     [NUM_CH];
  logic             pend   [NUM_CH];
  logic [ACC_W-1:0] acc    [NUM_CH];

  logic                    accept;
  logic [ACC_W-1:0]        cur_acc;
  logic [OUT_W-1:0]        p;
  logic [OUT_W-2:0]        fold;
  logic [OUT_W-1:0]        wave;
  logic signed [OUT_W+8:0] prod;
  logic [OUT_W-1:0]        voice;
  logic [LFSR_W-1:0]       lfsr_nxt;
  logic [OUT_W-1:0]        sat;

  assign accept   = (state == S_IDLE) && sample_strobe;
  assign cur_acc  = acc[ch];
  assign p        = cur_acc[ACC_W-1 -: OUT_W];
  assign fold     = p[OUT_W-1] ? ~p[OUT_W-2:0] : p[OUT_W-2:0];
  assign lfsr_nxt = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);

  // Waveform of the voice selected by ch, from its pre-update phase
  always_comb begin
    wave = '0;
    case (mode[ch])
      2'd0:    wave = {~p[OUT_W-1], p[OUT_W-2:0]};
      2'd1:    wave = cur_acc[ACC_W-1] ? SQ_NEG : OUT_MAX;
      2'd2:    wave = {~fold[OUT_W-2], fold[OUT_W-3:0], 1'b0};
      default: wave = lfsr[OUT_W-1:0];
    endcase
  end

  // Gain scaling (signed wave x unsigned gain, arithmetic >>> 8) and saturation
  always_comb begin
    prod  = $signed({{9{wave[OUT_W-1]}}, wave}) * $signed({{OUT_W{1'b0}}, 1'b0, gain[ch]});
    voice = en[ch] ? OUT_W'(prod >>> 8) : '0;
    if (mix > MIX_MAX)      sat = OUT_MAX;
    else if (mix < MIX_MIN) sat = OUT_MIN;
    else                    sat = mix[OUT_W-1:0];
  end

  // Shadow register writes; a one-shot phase load is consumed by the accepting strobe
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        inc_sh[i] <= '0; ld_sh[i] <= '0; mode_sh[i] <= '0;
        gain_sh[i] <= '0; en_sh[i] <= 1'b0; pend_sh[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (accept) pend_sh[i] <= 1'b0;
        if (cfg_wr && (cfg_chan == CH_W'(i))) begin
          case (cfg_sel)
            2'd0: inc_sh[i] <= cfg_data;
            2'd1: begin
              mode_sh[i] <= cfg_data[1:0];
              en_sh[i]   <= cfg_data[2];
              gain_sh[i] <= cfg_data[15:8];
            end
            2'd2: begin
              pend_sh[i] <= 1'b1;
              ld_sh[i]   <= cfg_data;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Active settings snapshot at strobe; per-voice phase update during CALC
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        inc[i] <= '0; ld[i] <= '0; mode[i] <= '0; gain[i] <= '0;
        en[i] <= 1'b0; pend[i] <= 1'b0; acc[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < NUM_CH; i++) begin
        inc[i] <= inc_sh[i]; ld[i] <= ld_sh[i]; mode[i] <= mode_sh[i];
        gain[i] <= gain_sh[i]; en[i] <= en_sh[i]; pend[i] <= pend_sh[i];
      end
    end else if (state == S_CALC) begin
      acc[ch]  <= pend[ch] ? ld[ch] : cur_acc + inc[ch];
      pend[ch] <= 1'b0;
    end
  end

  // Voice index, mix accumulator and noise LFSR
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ch   <= '0;
      mix  <= '0;
      lfsr <= LFSR_W'(1);
    end else if (accept) begin
      ch  <= '0;
      mix <= '0;
    end else if (state == S_CALC) begin
      ch  <= ch + CH_W'(1);
      mix <= mix + {{(MIX_W-OUT_W){voice[OUT_W-1]}}, voice};
      if (mode[ch] == 2'd3) lfsr <= lfsr_nxt;
    end
  end

  // Drop counter, held output sample and sticky strobe-miss flag
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      drop_count  <= '0;
      last_data   <= '0;
      strobe_miss <= 1'b0;
    end else begin
      if (state == S_PUSH) begin
        if (!fifo_full)                 last_data  <= sat;
        else if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
      if (sample_strobe && (state != S_IDLE)) strobe_miss <= 1'b1;
      else if (cfg_wr && (cfg_sel == 2'd3))   strobe_miss <= 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= S_IDLE;
    else                state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (sample_strobe) state_nxt = S_CALC;
      S_CALC:  if (ch == LAST_CH) state_nxt = S_PUSH;
      S_PUSH:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs; fifo_data shows the new sample only during a write
  always_comb begin
    busy       = (state != S_IDLE);
    fifo_wrreq = (state == S_PUSH) && !fifo_full;
    fifo_data  = fifo_wrreq ? sat : last_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_dds_multi_voice_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_dds_multi_voice_gen
// Desc     : Self-checking bench for dds_multi_voice_gen with a frame-level
//            behavioural reference model and randomized stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dds_multi_voice_gen;
  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        rst_n, strobe, wr, full;
  logic [1:0]  chan, sel;
  logic [31:0] data;
  logic        fifo_wrreq, busy, strobe_miss;
  logic [15:0] fifo_data, drop_count;

  dds_multi_voice_gen #(.NUM_CH(NCH)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .sample_strobe(strobe),
    .cfg_wr(wr), .cfg_chan(chan), .cfg_sel(sel), .cfg_data(data),
    .fifo_full(full), .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data),
    .busy(busy), .drop_count(drop_count), .strobe_miss(strobe_miss)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  logic [31:0] s_inc[NCH], s_ld[NCH], a_inc[NCH], a_ld[NCH], m_acc[NCH];
  int          s_mode[NCH], s_gain[NCH], a_mode[NCH], a_gain[NCH];
  bit          s_en[NCH], s_pend[NCH], a_en[NCH], a_pend[NCH];
  logic [31:0] m_lfsr;
  int          m_left, m_drop, m_writes, seen_writes;
  logic [15:0] m_exp, m_last;
  bit          m_miss;

  task automatic model_reset();
    for (int v = 0; v < NCH; v++) begin
      s_inc[v] = 0; s_ld[v] = 0; s_mode[v] = 0; s_gain[v] = 0; s_en[v] = 0; s_pend[v] = 0;
      a_inc[v] = 0; a_ld[v] = 0; a_mode[v] = 0; a_gain[v] = 0; a_en[v] = 0; a_pend[v] = 0;
      m_acc[v] = 0;
    end
    m_lfsr = 32'd1; m_left = 0; m_drop = 0; m_exp = 0; m_last = 0; m_miss = 0;
  endtask

  // Whole-frame result computed at acceptance from the frozen settings
  task automatic model_frame();
    int mix = 0;
    for (int v = 0; v < NCH; v++) begin
      logic [31:0] a = m_acc[v];
      int p = int'(a[31:16]);
      int w = 0;
      case (a_mode[v])
        0: w = p - 32768;
        1: w = a[31] ? -32767 : 32767;
        2: w = 2 * ((p < 32768) ? p : 65535 - p) - 32768;
        default: begin
          w = int'(m_lfsr[15:0]);
          if (w > 32767) w -= 65536;
          m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 32'h80200003) : (m_lfsr >> 1);
        end
      endcase
      if (a_en[v]) mix += (w * a_gain[v]) >>> 8;
      m_acc[v] = a_pend[v] ? a_ld[v] : a + a_inc[v];
    end
    if (mix > 32767) mix = 32767;
    if (mix < -32768) mix = -32768;
    m_exp = 16'(mix);
  endtask

  task automatic model_edge();
    bit acc_now = (m_left == 0) && strobe;
    if (m_left == 1) begin
      if (full) begin if (m_drop < 65535) m_drop++; end
      else begin m_last = m_exp; m_writes++; end
    end
    if (strobe && m_left > 0) m_miss = 1;
    else if (wr && sel == 2'd3) m_miss = 0;
    if (m_left > 0) m_left--;
    if (acc_now) begin
      for (int v = 0; v < NCH; v++) begin
        a_inc[v] = s_inc[v]; a_ld[v] = s_ld[v]; a_mode[v] = s_mode[v];
        a_gain[v] = s_gain[v]; a_en[v] = s_en[v]; a_pend[v] = s_pend[v]; s_pend[v] = 0;
      end
      model_frame();
      m_left = NCH + 1;
    end
    if (wr) begin
      case (sel)
        2'd0: s_inc[chan] = data;
        2'd1: begin s_mode[chan] = int'(data[1:0]); s_en[chan] = data[2]; s_gain[chan] = int'(data[15:8]); end
        2'd2: begin s_pend[chan] = 1; s_ld[chan] = data; end
        default: ;
      endcase
    end
  endtask

  // One clock cycle: inputs already driven; check mid-cycle, then advance model
  task automatic run_cycle();
    bit push;
    if (!rst_n) model_reset();
    @(negedge clk);
    push = (m_left == 1) && !full;
    check_val("busy", busy, m_left > 0);
    check_val("wrreq", fifo_wrreq, push);
    check_val("data", fifo_data, push ? m_exp : m_last);
    check_val("drop_count", drop_count, m_drop);
    check_val("strobe_miss", strobe_miss, m_miss);
    if (fifo_wrreq) seen_writes++;
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    strobe = 0; wr = 0;
  endtask

  task automatic frame();
    strobe = 1; run_cycle();
    repeat (NCH + 1) run_cycle();
  endtask

  task automatic cfg(input int c, input int s, input logic [31:0] d);
    wr = 1; chan = 2'(c); sel = 2'(s); data = d; run_cycle();
  endtask

  initial begin
    m_writes = 0; seen_writes = 0;
    strobe = 0; wr = 0; chan = 0; sel = 0; data = 0; full = 0;
    rst_n = 1;
    #2 rst_n = 0;
    model_reset();
    repeat (2) run_cycle();
    rst_n = 1;
    run_cycle();

    // Saw ramp on voice 0
    cfg(0, 1, 32'h0000FF04);
    cfg(0, 0, 32'h1000_0000);
    repeat (16) frame();

    // Two in-phase squares, full gain then half gain
    cfg(0, 1, 32'h0000FF05); cfg(1, 1, 32'h0000FF05);
    cfg(0, 0, $urandom); cfg(1, 0, 32'h0); cfg(0, 2, 0); cfg(1, 2, 0);
    repeat (3) frame();
    cfg(0, 1, 32'h00008005); cfg(1, 1, 32'h00008005);
    cfg(0, 2, 0); cfg(1, 2, 0); cfg(0, 0, 0);
    repeat (3) frame();

    // FIFO full for three frames, then released
    full = 1; repeat (3) frame();
    full = 0; frame();

    // Strobes every other cycle, then clear the sticky miss flag
    for (int i = 0; i < 12; i++) begin strobe = 1; run_cycle(); run_cycle(); end
    repeat (NCH + 1) run_cycle();
    cfg(0, 3, $urandom);

    // Mid-frame phase load on voice 2
    cfg(2, 1, 32'h0000FF00); cfg(2, 0, 32'h0123_4567);
    strobe = 1; run_cycle(); run_cycle();
    cfg(2, 2, 32'h8000_0000);
    repeat (NCH - 1) run_cycle();
    repeat (3) frame();

    // Noise voices from reset, then reset in the middle of CALC
    rst_n = 0; run_cycle(); rst_n = 1; run_cycle();
    for (int v = 0; v < NCH; v++) cfg(v, 1, {16'h0, 8'($urandom), 8'h07});
    repeat (4) frame();
    strobe = 1; run_cycle(); run_cycle();
    rst_n = 0; run_cycle(); run_cycle();
    rst_n = 1; repeat (NCH + 4) run_cycle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      strobe = ($urandom_range(0, 2) == 0);
      full   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) begin
        wr = 1; chan = 2'($urandom); sel = 2'($urandom); data = $urandom;
      end
      if ($urandom_range(0, 149) == 0) rst_n = 0;
      run_cycle();
      rst_n = 1;
    end
    full = 0;
    repeat (NCH + 2) run_cycle();

    check_val("write_count", seen_writes, m_writes);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
